// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
//
// SPI mode-0 slave giving an external master burst read/write access to a
// bank of NUM_REGS byte registers with address auto-increment. All SPI pins
// are oversampled in the clk domain.
//
// A frame is a command byte {rw, addr[6:0]} (rw=1 -> write) followed by any
// number of data bytes. The command byte returns SIG on MISO. Register 0
// drives the LEDs.
//
// Parameters
//   ADDR_W   address bits, NUM_REGS = 2**ADDR_W (1..7)
//   NUM_LED  LEDs driven from reg[0][NUM_LED-1:0] (1..8)
//   SIG      byte shifted out during the command byte
//
// Ports
//   clk        system clock, posedge
//   rst        asynchronous active-low reset
//   cs         SPI chip select, active-low, asynchronous
//   sck        SPI clock (CPOL=0, CPHA=0), asynchronous
//   MOSI       SPI data in, MSB first
//   MISO       SPI data out, MSB first, 0 outside a frame
//   led        reg[0][NUM_LED-1:0]
//   wr_strobe  one-clk pulse per committed register write
//   wr_addr    address of the last write (held)
//   wr_data    data of the last write (held)
//   busy       high while a frame is active
// -----------------------------------------------------------------------------
module spi_reg_slave #(
  parameter int          ADDR_W  = 3,
  parameter int          NUM_LED = 1,
  parameter logic [7:0]  SIG     = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               sck,
  input  logic               MOSI,
  output logic               MISO,
  output logic [NUM_LED-1:0] led,
  output logic               wr_strobe,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. Stages [0],[1] form the 2-FF synchroniser; stage [2]
  // is the edge-detect history. cs resets to 0 so that a frame already in
  // progress when reset releases is never mistaken for a fresh cs fall: only
  // a genuine high->low transition afterwards opens a frame.
  // ---------------------------------------------------------------------------
  logic [2:0] cs_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q   <= 3'b000;
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], cs};
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  logic cs_fall, cs_rise, sck_rise, sck_fall, mosi_s;
  assign cs_fall  =  cs_q[2]  & ~cs_q[1];
  assign cs_rise  = ~cs_q[2]  &  cs_q[1];
  assign sck_rise = ~sck_q[2] &  sck_q[1];
  assign sck_fall =  sck_q[2] & ~sck_q[1];
  assign mosi_s   =  mosi_q[1];

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [6:0]        rx_q,        rx_d;
  logic [7:0]        tx_q,        tx_d;
  logic              skip_q,      skip_d;      // suppress shift after a byte load
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic              wr_pend_q,   wr_pend_d;   // completed write byte awaiting commit
  logic [7:0]        wr_byte_q,   wr_byte_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [7:0]        wr_data_q,   wr_data_d;

  logic [7:0]        regs_q [NUM_REGS];

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic              byte_done;

  assign rx_byte   = {rx_q, mosi_s};
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
      skip_q      <= 1'b0;
      ptr_q       <= '0;
      wr_pend_q   <= 1'b0;
      wr_byte_q   <= 8'd0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      skip_q      <= skip_d;
      ptr_q       <= ptr_d;
      wr_pend_q   <= wr_pend_d;
      wr_byte_q   <= wr_byte_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    skip_d      = skip_q;
    ptr_d       = ptr_q;
    wr_pend_d   = 1'b0;
    wr_byte_d   = wr_byte_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (cs_rise) begin
      // Any partially shifted byte is simply dropped here.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            tx_d      = SIG;
            bit_cnt_d = 3'd0;
            skip_d    = 1'b0;
          end
        end
        default: begin
          if (sck_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done) begin
              skip_d = 1'b1;
              case (state_q)
                CMD: begin
                  if (rx_byte[7]) begin
                    state_d = WR;
                    ptr_d   = cmd_addr;
                    tx_d    = 8'h00;
                  end else begin
                    // First read byte is fetched right at the command
                    // boundary so it is ready for the next falling edge.
                    state_d = RD;
                    tx_d    = regs_q[cmd_addr];
                    ptr_d   = cmd_addr + ADDR_W'(1);
                  end
                end
                WR: begin
                  wr_pend_d = 1'b1;
                  wr_byte_d = rx_byte;
                  tx_d      = 8'h00;
                end
                default: begin  // RD: incoming byte is discarded
                  tx_d  = regs_q[ptr_q];
                  ptr_d = ptr_q + ADDR_W'(1);
                end
              endcase
            end
          end else if (sck_fall) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
      endcase
    end

    // Commit lands one clk after the byte completes; the master's minimum
    // sck phase guarantees no other pointer update falls in this cycle.
    if (wr_pend_q) begin
      wr_strobe_d = 1'b1;
      wr_addr_d   = ptr_q;
      wr_data_d   = wr_byte_q;
      ptr_d       = ptr_q + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          regs_q[gi] <= 8'd0;
        end else if (wr_pend_q && (ptr_q == ADDR_W'(gi))) begin
          regs_q[gi] <= wr_byte_q;
        end
      end
    end
  endgenerate

  assign busy      = (state_q != IDLE);
  assign MISO      = busy & tx_q[7];
  assign led       = regs_q[0][NUM_LED-1:0];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
module tb_spi_reg_slave;

  localparam int         ADDR_W  = 3;
  localparam int         NUM_LED = 1;
  localparam int         NREGS   = 8;
  localparam logic [7:0] SIG     = 8'hA5;

  logic               clk;
  logic               rst;
  logic               cs;
  logic               sck;
  logic               MOSI;
  logic               MISO;
  logic [NUM_LED-1:0] led;
  logic               wr_strobe;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         wr_data;
  logic               busy;

  spi_reg_slave #(
    .ADDR_W  (ADDR_W),
    .NUM_LED (NUM_LED),
    .SIG     (SIG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .sck       (sck),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .led       (led),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: register contents and the writes they imply.
  logic [7:0]        mregs [NREGS];
  logic [10:0]       got_q [$];
  logic [10:0]       exp_q [$];

  logic [9:0][7:0]   fb;           // frame bytes sent by the master
  logic [9:0][7:0]   got;          // bytes captured from MISO
  logic [9:0][7:0]   model_miso;   // bytes the model expects on MISO

  typedef struct {
    int              n;
    logic [9:0][7:0] b;
    logic [9:0][7:0] exp_miso;
    logic            exp_led;
    int              exp_strobes;
  } vec_t;

  vec_t tv [5];

  always @(negedge clk) begin
    if (rst && wr_strobe) got_q.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Frame semantics: command returns SIG; a write frame stores successive
  // bytes at addr, addr+1, ... wrapping; a read frame returns them.
  task automatic model_frame(input int n);
    int a;
    a = int'(fb[0]) % NREGS;
    model_miso = '0;
    model_miso[0] = SIG;
    for (int i = 1; i < n; i++) begin
      if (fb[0][7]) begin
        mregs[a] = fb[i];
        exp_q.push_back({a[ADDR_W-1:0], fb[i]});
      end else begin
        model_miso[i] = mregs[a];
      end
      a = (a + 1) % NREGS;
    end
  endtask

  // Master: n full bytes plus pbits extra bits; optional reset pulse just
  // before bit index rst_bit. sck phases are 6 clk each.
  task automatic spi_frame(input int n, input int pbits, input int rst_bit);
    int total;
    got = '0;
    @(negedge clk) cs = 1'b0;
    repeat (6) @(negedge clk);
    total = n * 8 + pbits;
    for (int k = 0; k < total; k++) begin
      if (k == rst_bit) begin
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mid_frame", {MISO, busy, wr_strobe, wr_addr, wr_data, led}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < NREGS; r++) mregs[r] = 8'h00;
      end
      MOSI = fb[k / 8][7 - (k % 8)];
      repeat (6) @(negedge clk);
      got[k / 8][7 - (k % 8)] = MISO;
      if (k == 0) chk("busy_in_frame", busy, 1);
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_after_frame", busy, 0);
    chk("miso_idle", MISO, 0);
  endtask

  task automatic compare_strobes();
    int m;
    chk("strobe_count", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk("strobe_addr_data", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst  = 1'b0;
    cs   = 1'b1;
    sck  = 1'b0;
    MOSI = 1'b0;
    for (int r = 0; r < NREGS; r++) mregs[r] = 8'h00;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {MISO, busy, wr_strobe, wr_addr, wr_data, led}, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_release", {MISO, busy, wr_strobe, led}, 0);

    // Directed vectors with hand-derived expectations.
    tv[0].n = 9; tv[0].b = '0;
    tv[0].exp_miso = '0; tv[0].exp_miso[0] = 8'hA5;
    tv[0].exp_led = 1'b0; tv[0].exp_strobes = 0;

    tv[1].n = 2; tv[1].b = '0; tv[1].b[0] = 8'h80; tv[1].b[1] = 8'h03;
    tv[1].exp_miso = '0; tv[1].exp_miso[0] = 8'hA5;
    tv[1].exp_led = 1'b1; tv[1].exp_strobes = 1;

    tv[2].n = 4; tv[2].b = '0; tv[2].b[0] = 8'h86;
    tv[2].b[1] = 8'h11; tv[2].b[2] = 8'h22; tv[2].b[3] = 8'h33;
    tv[2].exp_miso = '0; tv[2].exp_miso[0] = 8'hA5;
    tv[2].exp_led = 1'b1; tv[2].exp_strobes = 3;

    tv[3].n = 4; tv[3].b = '0; tv[3].b[0] = 8'h06;
    tv[3].exp_miso = '0; tv[3].exp_miso[0] = 8'hA5;
    tv[3].exp_miso[1] = 8'h11; tv[3].exp_miso[2] = 8'h22; tv[3].exp_miso[3] = 8'h33;
    tv[3].exp_led = 1'b1; tv[3].exp_strobes = 0;

    tv[4].n = 2; tv[4].b = '0; tv[4].b[0] = 8'h81; tv[4].b[1] = 8'h5A;
    tv[4].exp_miso = '0; tv[4].exp_miso[0] = 8'hA5;
    tv[4].exp_led = 1'b1; tv[4].exp_strobes = 1;

    for (int i = 0; i < 5; i++) begin
      fb = tv[i].b;
      model_frame(tv[i].n);
      spi_frame(tv[i].n, 0, -1);
      for (int j = 0; j < tv[i].n; j++) chk($sformatf("tbl%0d_miso%0d", i, j), got[j], tv[i].exp_miso[j]);
      chk($sformatf("tbl%0d_led", i), led, tv[i].exp_led);
      chk($sformatf("tbl%0d_strobes", i), got_q.size(), tv[i].exp_strobes);
      compare_strobes();
      $display("vector %0d: n=%0d cmd=%02h miso0=%02h led=%0b", i, tv[i].n, tv[i].b[0], got[0], led);
    end

    // Partial byte: write command then only 5 data bits -> nothing committed.
    fb = '0; fb[0] = 8'h81; fb[1] = 8'hFF;
    model_frame(1);
    spi_frame(1, 5, -1);
    compare_strobes();
    $display("partial frame: cmd=81 + 5 bits");
    fb = '0; fb[0] = 8'h01;
    model_frame(2);
    spi_frame(2, 0, -1);
    chk("partial_reg1", got[1], 8'h5A);
    chk("partial_reg1_model", got[1], model_miso[1]);
    compare_strobes();
    $display("readback reg1=%02h", got[1]);

    // Reset during bit 4 of the data byte; the rest of the frame is ignored.
    fb = '0; fb[0] = 8'h80; fb[1] = 8'h55;
    spi_frame(2, 0, 12);
    compare_strobes();
    chk("led_after_reset", led, 0);
    $display("aborted frame: cmd=80 reset at bit 12");
    fb = '0; fb[0] = 8'h82; fb[1] = 8'h7E;
    model_frame(2);
    spi_frame(2, 0, -1);
    compare_strobes();
    $display("write after reset: cmd=82 data=7E");
    fb = '0; fb[0] = 8'h00;
    model_frame(9);
    spi_frame(9, 0, -1);
    for (int j = 0; j < 9; j++) chk($sformatf("post_reset_read%0d", j), got[j], model_miso[j]);
    chk("post_reset_reg2", got[3], 8'h7E);
    compare_strobes();
    $display("full readback after reset: reg2=%02h", got[3]);

    // Randomised frames against the reference model.
    for (int t = 0; t < 15; t++) begin
      int n;
      n = $urandom_range(1, 7);
      fb = '0;
      for (int j = 0; j < n; j++) fb[j] = 8'($urandom);
      model_frame(n);
      spi_frame(n, 0, -1);
      for (int j = 0; j < n; j++) chk($sformatf("rnd%0d_miso%0d", t, j), got[j], model_miso[j]);
      chk($sformatf("rnd%0d_led", t), led, mregs[0][0]);
      compare_strobes();
      $display("random %0d: n=%0d cmd=%02h", t, n, fb[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave with an addressed register bank, successor to the fixed single-byte echo slave. An external SPI master (ESP32 on the board) issues a command byte followed by any number of data bytes to burst-write or burst-read a bank of byte registers with address auto-increment. Register 0 drives the board LEDs directly. All SPI pins are oversampled in the system clock domain, typically the 30 MHz PLL output.

## Interface
- ADDR_W, 3: address bits; NUM_REGS = 2**ADDR_W registers, legal range 1..7.
- NUM_LED, 1: LED outputs taken from reg[0][NUM_LED-1:0], legal range 1..8.
- SIG, 8'hA5: byte returned on MISO during the command byte.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- cs  in  1  SPI chip select, active-low, asynchronous to clk.
- sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- MOSI  in  1  SPI data in, MSB first.
- MISO  out  1  SPI data out, MSB first; 0 while cs high.
- led  out  NUM_LED  reg[0][NUM_LED-1:0].
- wr_strobe  out  1  one-clk pulse per committed register write.
- wr_addr  out  ADDR_W  address of the write; valid with wr_strobe, held afterwards.
- wr_data  out  8  data of the write; valid with wr_strobe, held afterwards.
- busy  out  1  high while a frame is active (synchronised cs low).

## Operation
- cs, sck and MOSI each pass through a 2-FF synchroniser. Edge detection compares synchroniser stage 2 with a third register.
- Frame layout: byte 0 is the command, {rw, addr[6:0]}. rw=1 means write. Only addr[ADDR_W-1:0] is used; upper bits are ignored.
- FSM states and transitions:
  - IDLE -> CMD on cs fall. The tx shift register loads SIG, bit count is 0.
  - CMD -> WR or RD after the 8th sampled bit. The pointer is set to addr.
  - Any state -> IDLE on cs rise.
- MOSI is sampled on each sck rising edge. The tx shift register shifts left on each sck falling edge, except the falling edge right after a byte boundary: the next byte is already loaded there.
- WR: on the 8th rising edge of each data byte, the next clk writes reg[ptr] <= byte. wr_strobe pulses, wr_addr/wr_data update, and ptr <= ptr+1 mod NUM_REGS.
- RD: on the 8th rising edge of the command byte and of every data byte, tx loads reg[ptr] and ptr increments mod NUM_REGS. Bytes received on MOSI in RD are discarded.
- In CMD and WR, tx loads 8'h00 at each byte boundary.
- A partial byte (fewer than 8 bits) at cs rise is discarded: no write, no strobe.
- Read and write in the same clk to the same register cannot occur, since a frame is either RD or WR.
- Reset values: every register 0, led 0, MISO 0, wr_strobe 0, wr_addr 0, wr_data 0, busy 0, FSM IDLE.
- Reset asserted mid-frame aborts the frame. After release, the frame is only recognised from the next cs fall.

## Timing
- Pin-to-detect latency: a pin change is acted on at the 3rd clk rising edge after it.
- Master requirements:
  - sck high and low phases each ≥ 4 clk periods.
  - cs fall to first sck rise ≥ 5 clk.
  - Last sck fall to cs rise ≥ 4 clk.
- MISO first bit (SIG[7]) is valid ≤ 4 clk after cs fall. Later bits change ≤ 4 clk after the sck falling pin edge.
- Write commit: the register, led, wr_strobe and wr_data update 4 clk after the pin rising edge of bit 7 of the byte.
- busy rises 3 clk after cs fall and falls 3 clk after cs rise.
- ptr wraps NUM_REGS-1 -> 0 silently. Bursts of any length are allowed.

## Test plan
- Reset: hold rst=0 for 5 clk -> all outputs 0, MISO 0; registers read back 0x00.
- Single write: frame {0x80, 0x03} -> one wr_strobe with wr_addr=0, wr_data=0x03; led=0x1 (NUM_LED=1).
- Burst write with wrap (ADDR_W=3): {0x86, 0x11, 0x22, 0x33} -> reg6=0x11, reg7=0x22, reg0=0x33; three strobes.
- Burst read: after the write above, send {0x06, 0x00, 0x00, 0x00} -> MISO bytes A5, 11, 22, 33.
- Partial byte: write frame {0x81} followed by 5 bits, then cs rise -> no strobe, reg1 unchanged; the next frame behaves normally.
- Reset mid-frame: assert rst during bit 4 of a data byte -> outputs 0 immediately; the next full frame {0x82, 0x7E} writes reg2=0x7E.
